// File: rtl/otter_crypto_pkg.sv
// Shared types and constants for the OTTER crypto control unit: opcodes,
// crypto func3 encodings, FSM states and register-file write-mux selects.
package otter_crypto_pkg;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011,
      ENCRY     = 7'b0011100
   } opcode_t;

   typedef enum logic [2:0] {
      F3_KEYSEL  = 3'b001,
      F3_ENCRYPT = 3'b010,
      F3_DECRYPT = 3'b011
   } crypto_func3_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      ROUND,
      WB
   } cu_state_t;

   localparam logic [2:0] WR_SEL_CRYPTO  = 3'd4;
   localparam logic [2:0] WR_SEL_DEFAULT = 3'd3;

endpackage

// File: rtl/otter_crypto_round_ctr.sv
// Round counter for the crypto control unit: synchronous clear, increment,
// and a terminal-count flag raised on the last round (NUM_ROUNDS-1).
module otter_crypto_round_ctr #(
   parameter int NUM_ROUNDS = 8,
   parameter int RW         = $clog2(NUM_ROUNDS) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [RW-1:0] cnt,
   output logic          tc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + RW'(1);
   end

   assign tc = (cnt == RW'(NUM_ROUNDS - 1));

endmodule

// File: rtl/otter_crypto_cu.sv
// OTTER crypto control unit: decodes ENCRY instructions, sequences the crypto
// engine and writes back the result. Decrypt support: OTTER_CRYPTO_DECRYPT_EN.
module otter_crypto_cu
   import otter_crypto_pkg::*;
#(
   parameter int NUM_ROUNDS = 8,
   parameter int KEY_SLOTS  = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [6:0]                    CU_OPCODE,
   input  logic [2:0]                    CU_FUNC3,
   input  logic [6:0]                    CU_FUNC7,
   input  logic                          INSTR_VALID,
   input  logic                          INT_TAKEN,
   input  logic                          ENG_READY,
   input  logic                          ENG_DONE,
   output logic                          CU_STALL,
   output logic                          CRYPTO_SEL,
   output logic                          ENG_START,
   output logic [$clog2(NUM_ROUNDS):0]   ENG_ROUND,
   output logic [$clog2(KEY_SLOTS)-1:0]  KEY_SLOT,
   output logic [2:0]                    CU_RF_WR_SEL,
   output logic                          RF_WR_EN,
   output logic                          BUSY,
   output logic                          ILLEGAL
);

   localparam int RW = $clog2(NUM_ROUNDS) + 1;
   localparam int KW = $clog2(KEY_SLOTS);

   cu_state_t     state;
   logic          enc_hit;
   logic          op_keysel;
   logic          op_run;
   logic          crypto_sel_q;
   logic          illegal_q;
   logic [KW-1:0] key_slot_q;
   logic          ctr_clr;
   logic          ctr_inc;
   logic          ctr_tc;
   logic [RW-1:0] ctr_cnt;
   logic          func7_unused;

   // Only the low slot-index bits of func7 carry meaning.
   assign func7_unused = ^CU_FUNC7;

   assign enc_hit   = INSTR_VALID && (CU_OPCODE == ENCRY) && !INT_TAKEN && (state == IDLE);
   assign op_keysel = (CU_FUNC3 == F3_KEYSEL);
`ifdef OTTER_CRYPTO_DECRYPT_EN
   assign op_run    = (CU_FUNC3 == F3_ENCRYPT) || (CU_FUNC3 == F3_DECRYPT);
`else
   assign op_run    = (CU_FUNC3 == F3_ENCRYPT);
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         key_slot_q   <= '0;
         crypto_sel_q <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         case (state)
            IDLE: begin
               if (enc_hit) begin
                  if (op_keysel) begin
                     key_slot_q <= CU_FUNC7[KW-1:0];
                  end else if (op_run) begin
`ifdef OTTER_CRYPTO_DECRYPT_EN
                     crypto_sel_q <= CU_FUNC3[0];
`else
                     crypto_sel_q <= 1'b0;
`endif
                     state <= ISSUE;
                  end else begin
                     illegal_q <= 1'b1;
                  end
               end
            end
            ISSUE: if (ENG_READY) state <= ROUND;
            ROUND: if (ENG_DONE && ctr_tc) state <= WB;
            WB:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Counter restarts at the engine handshake and again once the result is written.
   assign ctr_clr = ((state == ISSUE) && ENG_READY) || (state == WB);
   assign ctr_inc = (state == ROUND) && ENG_DONE && !ctr_tc;

   otter_crypto_round_ctr #(
      .NUM_ROUNDS (NUM_ROUNDS),
      .RW         (RW)
   ) u_round_ctr (
      .clk (CLK),
      .rst (RST),
      .clr (ctr_clr),
      .inc (ctr_inc),
      .cnt (ctr_cnt),
      .tc  (ctr_tc)
   );

   // Stall covers the accept cycle combinationally so decode holds the instruction.
   assign CU_STALL     = (state == ISSUE) || (state == ROUND) || (enc_hit && op_run);
   assign ENG_START    = (state == ISSUE);
   assign RF_WR_EN     = (state == WB);
   assign CU_RF_WR_SEL = (state == WB) ? WR_SEL_CRYPTO : WR_SEL_DEFAULT;
   assign BUSY         = (state != IDLE);
   assign ENG_ROUND    = ctr_cnt;
   assign KEY_SLOT     = key_slot_q;
   assign CRYPTO_SEL   = crypto_sel_q;
   assign ILLEGAL      = illegal_q;

endmodule

// File: tb/tb_otter_crypto_cu.sv
// Directed bench for otter_crypto_cu (NUM_ROUNDS=4, KEY_SLOTS=4); decrypt
// expectations follow OTTER_CRYPTO_DECRYPT_EN.
module tb_otter_crypto_cu;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] cu_opcode;
   logic [2:0] cu_func3;
   logic [6:0] cu_func7;
   logic       instr_valid;
   logic       int_taken;
   logic       eng_ready;
   logic       eng_done;
   logic       cu_stall;
   logic       crypto_sel;
   logic       eng_start;
   logic [2:0] eng_round;
   logic [1:0] key_slot;
   logic [2:0] rf_wr_sel;
   logic       rf_wr_en;
   logic       busy;
   logic       illegal;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] OPC_ENCRY = 7'b0011100;
   localparam logic [6:0] OPC_REG   = 7'b0110011;

   otter_crypto_cu #(.NUM_ROUNDS(4), .KEY_SLOTS(4)) dut (
      .CLK          (clk),
      .RST          (rst),
      .CU_OPCODE    (cu_opcode),
      .CU_FUNC3     (cu_func3),
      .CU_FUNC7     (cu_func7),
      .INSTR_VALID  (instr_valid),
      .INT_TAKEN    (int_taken),
      .ENG_READY    (eng_ready),
      .ENG_DONE     (eng_done),
      .CU_STALL     (cu_stall),
      .CRYPTO_SEL   (crypto_sel),
      .ENG_START    (eng_start),
      .ENG_ROUND    (eng_round),
      .KEY_SLOT     (key_slot),
      .CU_RF_WR_SEL (rf_wr_sel),
      .RF_WR_EN     (rf_wr_en),
      .BUSY         (busy),
      .ILLEGAL      (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
      instr_valid = 1'b1;
      cu_opcode   = opc;
      cu_func3    = f3;
      cu_func7    = f7;
   endtask

   task automatic wait_wb(input int bound, output int cyc);
      cyc = 0;
      for (int i = 1; i <= bound; i++) begin
         tick();
         if (rf_wr_en) begin
            cyc = i;
            break;
         end
      end
      if (cyc == 0) chk("wb_seen", rf_wr_en, 1);
   endtask

   initial begin
      int stall_cnt;
      int wb_at;
      int start_cnt;
      int wr_cnt;
      int cyc;

      rst = 1'b1;
      cu_opcode = 7'd0; cu_func3 = 3'd0; cu_func7 = 7'd0;
      instr_valid = 1'b0; int_taken = 1'b0; eng_ready = 1'b0; eng_done = 1'b0;
      #2;
      chk("rst_wr_sel", rf_wr_sel, 3);
      chk("rst_busy",   busy, 0);
      chk("rst_stall",  cu_stall, 0);
      chk("rst_slot",   key_slot, 0);
      chk("rst_round",  eng_round, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // key select to slot 3, no stall
      drive(OPC_ENCRY, 3'b001, 7'h03);
      #1;
      chk("ks_stall", cu_stall, 0);
      tick();
      instr_valid = 1'b0;
      #1;
      chk("ks_slot", key_slot, 3);
      chk("ks_busy", busy, 0);

      // encrypt, engine always ready and done every cycle
      eng_ready = 1'b1; eng_done = 1'b1;
      drive(OPC_ENCRY, 3'b010, 7'h00);
      #1;
      chk("enc_acc_stall", cu_stall, 1);
      chk("enc_acc_busy", busy, 0);
      stall_cnt = 0; wb_at = 0;
      for (int k = 1; k <= 20 && wb_at == 0; k++) begin
         tick();
         if (k == 1) instr_valid = 1'b0;
         #1;
         if (k == 1) chk("enc_start_issue", eng_start, 1);
         if (k == 4) chk("enc_round_idx", eng_round, 2);
         if (rf_wr_en) begin
            wb_at = k;
            chk("enc_wb_sel", rf_wr_sel, 4);
            chk("enc_wb_stall", cu_stall, 0);
         end else if (cu_stall) begin
            stall_cnt++;
         end
      end
      chk("enc_wb_latency", wb_at, 6);
      chk("enc_stall_cycles", stall_cnt, 5);
      chk("enc_sel", crypto_sel, 0);
      eng_ready = 1'b0; eng_done = 1'b0;
      tick();
      chk("enc_idle_busy", busy, 0);
      chk("enc_idle_wr", rf_wr_en, 0);
      chk("enc_idle_sel", rf_wr_sel, 3);
      chk("enc_slot_kept", key_slot, 3);

      // engine not ready for 3 cycles; interrupt mid-op is ignored
      drive(OPC_ENCRY, 3'b010, 7'h00);
      #1;
      chk("rdy_acc_stall", cu_stall, 1);
      tick();
      instr_valid = 1'b0;
      int_taken = 1'b1;
      start_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rdy_wait_start", eng_start, 1);
         chk("rdy_wait_round", eng_round, 0);
         if (eng_start) start_cnt++;
         tick();
      end
      eng_ready = 1'b1;
      #1;
      if (eng_start) start_cnt++;
      tick();
      eng_ready = 1'b0;
      #1;
      chk("rdy_start_cnt", start_cnt, 4);
      chk("rdy_start_drop", eng_start, 0);
      chk("rdy_round0", eng_round, 0);
      chk("rdy_in_round", cu_stall, 1);
      eng_done = 1'b1;
      wait_wb(8, cyc);
      chk("rdy_wb_lat", cyc, 4);
      eng_done = 1'b0;
      int_taken = 1'b0;
      tick();
      chk("rdy_idle", busy, 0);

      // non-ENCRY opcode: nothing happens
      drive(OPC_REG, 3'b010, 7'h00);
      #1;
      chk("oth_stall", cu_stall, 0);
      chk("oth_sel", rf_wr_sel, 3);
      tick();
      instr_valid = 1'b0;
      #1;
      chk("oth_busy", busy, 0);
      chk("oth_illegal", illegal, 0);

      // interrupt in accept cycle blocks, accepted next cycle
      eng_ready = 1'b1; eng_done = 1'b1;
      int_taken = 1'b1;
      drive(OPC_ENCRY, 3'b010, 7'h00);
      #1;
      chk("int_block_stall", cu_stall, 0);
      tick();
      chk("int_block_busy", busy, 0);
      int_taken = 1'b0;
      #1;
      chk("int_acc_stall", cu_stall, 1);
      tick();
      instr_valid = 1'b0;
      #1;
      chk("int_acc_busy", busy, 1);
      wait_wb(8, cyc);
      chk("int_wb_lat", cyc, 5);
      tick();

      // func3 = 011
      drive(OPC_ENCRY, 3'b011, 7'h00);
      #1;
`ifdef OTTER_CRYPTO_DECRYPT_EN
      chk("dec_stall", cu_stall, 1);
      tick();
      instr_valid = 1'b0;
      #1;
      chk("dec_busy", busy, 1);
      wait_wb(8, cyc);
      chk("dec_wb_lat", cyc, 5);
      chk("dec_sel", crypto_sel, 1);
      tick();
`else
      chk("dec_ill_stall", cu_stall, 0);
      tick();
      instr_valid = 1'b0;
      #1;
      chk("dec_ill_pulse", illegal, 1);
      chk("dec_ill_busy", busy, 0);
      chk("dec_ill_sel", crypto_sel, 0);
      tick();
      chk("dec_ill_clear", illegal, 0);
`endif

      // unsupported func3 = 111
      drive(OPC_ENCRY, 3'b111, 7'h00);
      #1;
      chk("ill_stall", cu_stall, 0);
      tick();
      instr_valid = 1'b0;
      #1;
      chk("ill_pulse", illegal, 1);
      chk("ill_busy", busy, 0);
      tick();
      chk("ill_clear", illegal, 0);

      // async reset mid-operation at round 2
      eng_ready = 1'b1; eng_done = 1'b0;
      drive(OPC_ENCRY, 3'b010, 7'h00);
      tick();
      instr_valid = 1'b0;
      tick();
      eng_done = 1'b1;
      tick();
      tick();
      eng_done = 1'b0;
      eng_ready = 1'b0;
      #1;
      chk("mid_round2", eng_round, 2);
      chk("mid_busy", busy, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_round", eng_round, 0);
      chk("arst_busy", busy, 0);
      chk("arst_stall", cu_stall, 0);
      chk("arst_start", eng_start, 0);
      chk("arst_wr_sel", rf_wr_sel, 3);
      chk("arst_slot", key_slot, 0);
      chk("arst_sel", crypto_sel, 0);
      tick();
      rst = 1'b0;
      wr_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (rf_wr_en) wr_cnt++;
      end
      chk("arst_no_wr", wr_cnt, 0);
      chk("arst_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
